bitrev_stream: RTL and testbench

Parametrised, streaming bit-reverse reorder buffer for the NTT datapath, sitting between the PE array output and the next transform stage. It accepts a transform frame of N coefficients as N/PE_NUMBER beats of PE_NUMBER lanes. It emits the frame in bit-reversed index order, also at full lane width. Two frame banks in ping-pong give sustained one-beat-per-cycle throughput, with valid/ready handshakes on both sides.

---
 rtl/bitrev_stream.sv | 169 ++++++++++++++++
 tb/tb_bitrev_stream.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bitrev_stream.sv
// bitrev_stream: streaming bit-reverse reorder buffer for the NTT datapath.
// Accepts a frame of 2**LOG_N coefficients as D = N/PE_NUMBER beats of PE_NUMBER lanes and
// emits it in bit-reversed index order. Two frame banks ping-pong so one frame fills while
// the previous one drains, giving one beat per cycle on both sides.
// Optional feature macro: BITREV_BYPASS_EN adds a 'bypass' input; a frame whose beat 0 is
// accepted with bypass=1 drains in natural order instead of bit-reversed order.
module bitrev_stream #(
  parameter int unsigned DATA_SIZE = 32,
  parameter int unsigned PE_NUMBER = 32,
  parameter int unsigned LOG_N     = 10
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [DATA_SIZE*PE_NUMBER-1:0] in_data,
`ifdef BITREV_BYPASS_EN
  input  logic                           bypass,
`endif
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [DATA_SIZE*PE_NUMBER-1:0] out_data,
  output logic                           out_last
);

  localparam int unsigned LogP     = $clog2(PE_NUMBER);
  localparam int unsigned LogD     = LOG_N - LogP;
  localparam int unsigned NumBeats = 1 << LogD;
  localparam int unsigned NumCoef  = 1 << LOG_N;
  localparam int unsigned BeatW    = DATA_SIZE * PE_NUMBER;
  localparam logic [LogD-1:0] LastBeat = LogD'(NumBeats - 1);

  typedef enum logic [1:0] {StEmpty, StFilling, StFull, StDraining} bank_state_e;

  function automatic logic [LOG_N-1:0] bitrev(input logic [LOG_N-1:0] a);
    logic [LOG_N-1:0] r;
    r = '0;
    for (int k = 0; k < int'(LOG_N); k++) r[k] = a[LOG_N-1-k];
    return r;
  endfunction

  // Frame storage, flat coefficient index per bank
  logic [DATA_SIZE-1:0] mem_q [2][NumCoef];

  bank_state_e [1:0] state_q;
  logic              wr_bank_q;
  logic [LogD-1:0]   wr_cnt_q;
  logic              rd_bank_q;
  logic [LogD-1:0]   rd_cnt_q;
  logic              out_valid_q;
  logic              out_last_q;
  logic [BeatW-1:0]  out_data_q;
`ifdef BITREV_BYPASS_EN
  logic [1:0]        byp_q;
`endif

  logic             wr_fire, wr_last, rd_last, pop, drain_done;
  logic             load_en, ld_bank, ld_byp;
  logic [LogD-1:0]  ld_cnt;
  logic [BeatW-1:0] ld_data;
  logic [LOG_N-1:0] nat_idx, src_idx;
  logic [DATA_SIZE-1:0] src_word;

  assign in_ready   = (state_q[wr_bank_q] == StEmpty) || (state_q[wr_bank_q] == StFilling);
  assign wr_fire    = in_valid && in_ready;
  assign wr_last    = (wr_cnt_q == LastBeat);
  assign rd_last    = (rd_cnt_q == LastBeat);
  assign pop        = out_valid_q && out_ready;
  assign drain_done = pop && rd_last;

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_data  = out_data_q;

  // Pick the next beat to load into the output register, if any
  always_comb begin
    load_en = 1'b0;
    ld_bank = rd_bank_q;
    ld_cnt  = '0;
    if (out_valid_q && !rd_last) begin
      load_en = out_ready;
      ld_cnt  = rd_cnt_q + 1'b1;
    end else if (!out_valid_q || out_ready) begin
      // Start of a frame: the bank may be full already or completing its fill this edge
      ld_bank = out_valid_q ? ~rd_bank_q : rd_bank_q;
      load_en = (state_q[ld_bank] == StFull) ||
                (wr_fire && wr_last && (wr_bank_q == ld_bank));
    end
  end

  // Gather the lanes of the next output beat, forwarding the beat being written this edge
  always_comb begin
`ifdef BITREV_BYPASS_EN
    ld_byp = byp_q[ld_bank];
`else
    ld_byp = 1'b0;
`endif
    ld_data  = '0;
    nat_idx  = '0;
    src_idx  = '0;
    src_word = '0;
    for (int l = 0; l < int'(PE_NUMBER); l++) begin
      nat_idx  = {ld_cnt, LogP'(l)};
      src_idx  = ld_byp ? nat_idx : bitrev(nat_idx);
      src_word = mem_q[ld_bank][src_idx];
      if (wr_fire && (wr_bank_q == ld_bank) && (wr_cnt_q == src_idx[LOG_N-1:LogP])) begin
        src_word = in_data[DATA_SIZE*int'(src_idx[LogP-1:0]) +: DATA_SIZE];
      end
      ld_data[DATA_SIZE*l +: DATA_SIZE] = src_word;
    end
  end

  // Store accepted beats; contents need no reset since bank state gates every read
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      for (int l = 0; l < int'(PE_NUMBER); l++) begin
        mem_q[wr_bank_q][{wr_cnt_q, LogP'(l)}] <= in_data[DATA_SIZE*l +: DATA_SIZE];
      end
    end
  end

  // Bank state machine, write/read pointers and registered output beat
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= {StEmpty, StEmpty};
      wr_bank_q   <= 1'b0;
      wr_cnt_q    <= '0;
      rd_bank_q   <= 1'b0;
      rd_cnt_q    <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
`ifdef BITREV_BYPASS_EN
      byp_q       <= '0;
`endif
    end else begin
      if (wr_fire) begin
`ifdef BITREV_BYPASS_EN
        if (wr_cnt_q == '0) byp_q[wr_bank_q] <= bypass;
`endif
        if (wr_last) begin
          state_q[wr_bank_q] <= StFull;
          wr_bank_q          <= ~wr_bank_q;
          wr_cnt_q           <= '0;
        end else begin
          state_q[wr_bank_q] <= StFilling;
          wr_cnt_q           <= wr_cnt_q + 1'b1;
        end
      end
      if (drain_done) begin
        state_q[rd_bank_q] <= StEmpty;
        rd_bank_q          <= ~rd_bank_q;
        rd_cnt_q           <= '0;
      end
      // Assigned last so a bank filling and starting to drain on one edge ends up draining
      if (load_en) begin
        out_valid_q <= 1'b1;
        out_data_q  <= ld_data;
        out_last_q  <= (ld_cnt == LastBeat);
        rd_bank_q   <= ld_bank;
        rd_cnt_q    <= ld_cnt;
        if (ld_cnt == '0) state_q[ld_bank] <= StDraining;
      end else if (pop) begin
        out_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bitrev_stream.sv
// Self-checking bench for bitrev_stream: default-size instance driven through a scoreboard,
// plus a PE_NUMBER=4, LOG_N=4 instance checked against fixed beat values.
module tb_bitrev_stream;

  localparam int DW = 32;
  localparam int PE = 32;
  localparam int LOGN = 10;
  localparam int D = 32;
  localparam int W = DW * PE;

  typedef struct {
    logic [W-1:0] data;
    logic         last;
  } beat_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_data;
  logic         out_last;
`ifdef BITREV_BYPASS_EN
  logic         bypass = 1'b0;
`endif

  logic        s_in_valid = 1'b0;
  logic        s_in_ready;
  logic [31:0] s_in_data = '0;
  logic        s_out_valid;
  logic        s_out_ready = 1'b0;
  logic [31:0] s_out_data;
  logic        s_out_last;

  bitrev_stream #(.DATA_SIZE(DW), .PE_NUMBER(PE), .LOG_N(LOGN)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
`ifdef BITREV_BYPASS_EN
    .bypass   (bypass),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_last (out_last)
  );

  bitrev_stream #(.DATA_SIZE(8), .PE_NUMBER(4), .LOG_N(4)) dut_small (
    .clk      (clk),
    .reset    (reset),
    .in_valid (s_in_valid),
    .in_ready (s_in_ready),
    .in_data  (s_in_data),
`ifdef BITREV_BYPASS_EN
    .bypass   (1'b0),
`endif
    .out_valid(s_out_valid),
    .out_ready(s_out_ready),
    .out_data (s_out_data),
    .out_last (s_out_last)
  );

  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  int last_acc = 0;
  int first_valid = -1;
  int run = 0;
  int max_run = 0;
  int n_out = 0;
  beat_t sb[$];
  logic [W-1:0] cap[$];
  logic [32:0] s_cap[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [9:0] rev10(input logic [9:0] a);
    logic [9:0] r;
    for (int k = 0; k < 10; k++) r[k] = a[9-k];
    return r;
  endfunction

  // Output monitor: every valid beat is compared to the scoreboard head, consumed on handshake
  always @(negedge clk) begin
    if (reset) begin
      if (out_valid) begin
        run++;
        if (run > max_run) max_run = run;
        if (first_valid < 0) first_valid = cyc;
        if (sb.size() == 0) begin
          check_eq("unexpected_beat", 64'd1, 64'd0);
        end else begin
          for (int l = 0; l < PE; l++) begin
            check_eq($sformatf("out_data b%0d l%0d", n_out, l),
                     64'(out_data[DW*l +: DW]), 64'(sb[0].data[DW*l +: DW]));
          end
          check_eq($sformatf("out_last b%0d", n_out), 64'(out_last), 64'(sb[0].last));
          if (out_ready) begin
            void'(sb.pop_front());
            cap.push_back(out_data);
            n_out++;
          end
        end
      end else begin
        run = 0;
      end
      if (s_out_valid && s_out_ready) s_cap.push_back({s_out_last, s_out_data});
    end
  end

  task automatic wait_accept();
    for (int t = 0; t <= 300; t++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        return;
      end
    end
    $display("FAIL accept_timeout: in_ready stuck low at cycle %0d", cyc);
    $fatal(1, "accept timeout");
  endtask

  // Drive nbeats of frame f; only complete frames are expected at the output
  task automatic send_frame(input int f, input int nbeats, input bit byp, input bit keep_valid);
    if (nbeats == D) begin
      for (int c = 0; c < D; c++) begin
        beat_t b;
        b.data = '0;
        for (int l = 0; l < PE; l++) begin
          int j;
          int src;
          j = c * PE + l;
          src = byp ? j : int'(rev10(10'(j)));
          b.data[DW*l +: DW] = DW'((f << 16) | src);
        end
        b.last = (c == D - 1);
        sb.push_back(b);
      end
    end
    for (int c = 0; c < nbeats; c++) begin
      in_valid = 1'b1;
      for (int l = 0; l < PE; l++) in_data[DW*l +: DW] = DW'((f << 16) | (c * PE + l));
`ifdef BITREV_BYPASS_EN
      bypass = byp;
`endif
      wait_accept();
      if (c == D - 1) last_acc = cyc;
    end
    if (!keep_valid) in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    for (int t = 0; t < 600 && sb.size() != 0; t++) @(negedge clk);
    check_eq(tag, 64'(sb.size()), 64'd0);
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_in_ready", 64'(in_ready), 64'd1);
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_out_last", 64'(out_last), 64'd0);
    check_eq("rst_out_data_zero", 64'(|out_data), 64'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Single frame with index data
    out_ready = 1'b1;
    first_valid = -1;
    cap.delete();
    send_frame(0, D, 1'b0, 1'b0);
    wait_drain("drain_f0");
    check_eq("fill_latency", 64'(first_valid), 64'(last_acc));
    check_eq("f0 b0 l0", 64'(cap[0][0 +: DW]), 64'd0);
    check_eq("f0 b0 l1", 64'(cap[0][DW +: DW]), 64'd512);
    check_eq("f0 b0 l2", 64'(cap[0][2*DW +: DW]), 64'd256);
    check_eq("f0 b1 l0", 64'(cap[1][0 +: DW]), 64'd16);

    // Three back-to-back frames, no bubbles on the output
    max_run = 0;
    send_frame(1, D, 1'b0, 1'b1);
    send_frame(2, D, 1'b0, 1'b1);
    send_frame(3, D, 1'b0, 1'b0);
    wait_drain("drain_f123");
    check_eq("no_bubble_run", 64'(max_run), 64'd96);

    // Backpressure: output held while the second bank fills, then in_ready drops
    out_ready = 1'b0;
    send_frame(4, D, 1'b0, 1'b0);
    send_frame(5, D, 1'b0, 1'b0);
    @(negedge clk);
    check_eq("bp_in_ready_low", 64'(in_ready), 64'd0);
    repeat (10) @(posedge clk);
    #1;
    check_eq("bp_out_valid_held", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    wait_drain("drain_f45");

    // Reset in the middle of a frame, then a fresh frame
    send_frame(6, 17, 1'b0, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    check_eq("midrst_out_valid", 64'(out_valid), 64'd0);
    check_eq("midrst_in_ready", 64'(in_ready), 64'd1);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    send_frame(7, D, 1'b0, 1'b0);
    wait_drain("drain_f7");
    repeat (8) @(posedge clk);
    #1;

`ifdef BITREV_BYPASS_EN
    // Alternating bypass frames: natural then bit-reversed order
    send_frame(8, D, 1'b1, 1'b1);
    send_frame(9, D, 1'b0, 1'b1);
    send_frame(10, D, 1'b1, 1'b0);
    wait_drain("drain_bypass");
`endif

    // Small configuration, lane value = coefficient index
    s_out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      logic [31:0] v;
      for (int l = 0; l < 4; l++) v[8*l +: 8] = 8'(4 * c + l);
      s_in_valid = 1'b1;
      s_in_data = v;
      for (int t = 0; t <= 50; t++) begin
        @(negedge clk);
        if (s_in_ready || t == 50) break;
      end
      @(posedge clk);
      #1;
    end
    s_in_valid = 1'b0;
    for (int t = 0; t < 50 && s_cap.size() < 4; t++) @(negedge clk);
    check_eq("small_beats", 64'(s_cap.size()), 64'd4);
    if (s_cap.size() >= 4) begin
      check_eq("small b0", 64'(s_cap[0][31:0]), 64'h0C04_0800);
      check_eq("small b1", 64'(s_cap[1][31:0]), 64'h0E06_0A02);
      check_eq("small b3", 64'(s_cap[3][31:0]), 64'h0F07_0B03);
      check_eq("small b0 last", 64'(s_cap[0][32]), 64'd0);
      check_eq("small b3 last", 64'(s_cap[3][32]), 64'd1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
